// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared types and constants for the tug-of-war press conditioning logic.
//   chan_state_e             : per-key debounce FSM state
//   DEBOUNCE_CYCLES_DEFAULT  : default number of stable synchronized cycles
//                              a key level must hold before it is accepted
// -----------------------------------------------------------------------------
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  // Legal range for DEBOUNCE_CYCLES is 2..255.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage : tow_pkg

// File: rtl/press_channel.sv
// -----------------------------------------------------------------------------
// press_channel
// One pushbutton conditioner: two-flop synchronizer, debounce FSM with a
// saturating counter, and a registered one-cycle press pulse.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   key_n_i     : raw active-low pushbutton, asynchronous to clk
//   pulse_en_i  : when 0 the accepted press is consumed but not emitted
//   pulse_o     : registered one-cycle pulse per accepted press
//
// Handshake: none; pulse_o is a fire-and-forget strobe, high for exactly one
// cycle per accepted press, with no back-pressure from the consumer.
// -----------------------------------------------------------------------------
module press_channel
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  input  logic pulse_en_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer: the key is inverted on entry so that 1 means "pressed".
  // Only the second flop (sync2_q) feeds any logic.
  logic sync1_q;
  logic sync2_q;
  logic s;

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             accept;

  assign s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // State register (FSM, counter, pulse register)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. The counter never wraps: reaching CNT_LAST always
  // coincides with a state transition that clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A press seen again before the release is confirmed is a bounce:
        // go back to HELD without emitting another pulse.
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: a press is accepted on the PRESS_WAIT -> HELD transition.
  // When disabled the press is still consumed by the FSM and never replayed.
  always_comb begin
    accept  = (state_q == PRESS_WAIT) && s && (cnt_q == CNT_LAST);
    pulse_d = accept && pulse_en_i;
  end

  assign pulse_o = pulse_q;

endmodule : press_channel

// File: rtl/press_conditioner.sv
// -----------------------------------------------------------------------------
// press_conditioner
// Conditions the two tug-of-war player pushbuttons into clean one-cycle press
// pulses. Two fully independent press_channel instances; no arbitration, so
// L and R may pulse together (downstream treats L&R as a cancel).
//
// Ports
//   clk       : clock
//   reset     : asynchronous active-low reset (deassertion is synchronized
//               by the top level, not here)
//   key_l_n   : raw left pushbutton, active-low, asynchronous
//   key_r_n   : raw right pushbutton, active-low, asynchronous
//   game_over : synchronous; while 1 no press pulses are emitted
//   L         : registered one-cycle pulse per accepted left press
//   R         : registered one-cycle pulse per accepted right press
// -----------------------------------------------------------------------------
module press_conditioner
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic game_over,
  output logic L,
  output logic R
);

  logic pulse_en;

  // game_over gates the pulse registers; the FSMs keep running so a press
  // accepted during game_over is swallowed rather than emitted later.
  assign pulse_en = ~game_over;

  press_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk       (clk),
    .rst_n     (reset),
    .key_n_i   (key_l_n),
    .pulse_en_i(pulse_en),
    .pulse_o   (L)
  );

  press_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk       (clk),
    .rst_n     (reset),
    .key_n_i   (key_r_n),
    .pulse_en_i(pulse_en),
    .pulse_o   (R)
  );

endmodule : press_conditioner

// File: doc/press_conditioner.md
PRESS_CONDITIONER -- requirements
Module: press_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive synchronized cycles a key level must hold to be accepted; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port key_l_n, input, 1 bit: raw left-player pushbutton, active-low, asynchronous to clk.
REQ-005 SHALL have port key_r_n, input, 1 bit: raw right-player pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port game_over, input, 1 bit: synchronous; while 1, no press pulses are emitted.
REQ-007 SHALL have port L, output, 1 bit: one-cycle pulse per accepted left press; feeds the playfield light cells.
REQ-008 SHALL have port R, output, 1 bit: one-cycle pulse per accepted right press.

Function
REQ-009 SHALL invert each key and pass it through a two-flop synchronizer; only the second-flop output s is used by any logic.
REQ-010 SHALL run one independent channel FSM per key, with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 IDLE: s=1 -> PRESS_WAIT with cnt=0; else stay.
REQ-012 PRESS_WAIT: s=0 -> IDLE, cnt=0; s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, emit pulse; s=1 otherwise -> cnt+1.
REQ-013 HELD: s=0 -> RELEASE_WAIT with cnt=0; else stay; never emit a further pulse while held.
REQ-014 RELEASE_WAIT: s=1 -> HELD, cnt=0, no pulse; s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; s=0 otherwise -> cnt+1.
REQ-015 Pulse outputs L/R SHALL be registered; high for exactly one cycle.
REQ-016 Latency: counting the first rising edge that samples the key pressed as edge 1, the pulse goes high after edge DEBOUNCE_CYCLES+3 (edge 7 at default) and low after the next edge.
REQ-017 game_over=1 SHALL force the registered pulse to 0 in that cycle; the FSM continues to advance, so a press accepted during game_over is consumed and never emitted later.
REQ-018 Both channels SHALL be fully independent; L and R may pulse in the same cycle, and no arbitration is done (downstream treats L&R as cancel).
REQ-019 Counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1, and a state transition occurs there.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no state change beyond PRESS_WAIT/RELEASE_WAIT.

Reset
REQ-021 reset=0 SHALL asynchronously clear both synchronizer flops, both FSMs to IDLE, counters to 0, and L=R=0.
REQ-022 Reset asserted mid-press SHALL discard the press; after release of reset with the key still held, a new full debounce SHALL occur and one pulse SHALL be emitted.
REQ-023 Reset deassertion need not be synchronized inside this block; the top level provides a synchronized deassert.

Structure
REQ-024 Package tow_pkg SHALL hold the channel state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the DEBOUNCE_CYCLES default constant.
REQ-025 Sub-module press_channel (sync + FSM + counter + pulse register, one key) SHALL be instantiated twice; press_conditioner adds only wiring and game_over gating.

Verification
REQ-026 Clean press: key_l_n low for 20 cycles, DEBOUNCE_CYCLES=4 -> L=1 only in the cycle after edge 7, R=0 throughout, and no second pulse before release.
REQ-027 Bounce: key_r_n low for 2 cycles, high for 1, then low for 10 -> exactly one R pulse, 7 edges after the start of the final low run.
REQ-028 Release bounce: after an accepted hold, key high for 2 cycles then low again for 10 -> no extra pulse; a later clean release of 4 or more cycles followed by a clean press -> exactly one new pulse.
REQ-029 Simultaneous press: both keys low on the same edge -> L and R pulse in the same cycle.
REQ-030 game_over=1 during the accepting edge -> L stays 0; dropping game_over while the key is still held -> still no pulse.
REQ-031 Reset: reset=0 asserted at cycle 4 of a held press, released at cycle 6 with the key held -> outputs 0 immediately, then one pulse 7 edges after reset release.
